// File: rtl/sp_ram_banked_wrap.sv
// Word-interleaved multi-bank single-port RAM with req/gnt/rvalid handshake,
// optional output register, per-access bypass and post-reset zero-fill sweep.

module sp_ram #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [AW-1:0]           addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < DATA_WIDTH/8; b++) begin
                    if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// state  | meaning
// S_INIT | zero-fill sweep, one row of every bank per cycle
// S_WAKE | single idle cycle after reset when no sweep is configured
// S_READY| accepting one access per cycle
module sp_ram_banked_wrap #(
    parameter int RAM_SIZE   = 32768,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int OUT_REG    = 0,
    parameter int INIT_EN    = 1
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    bypass_en_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    init_done_o
);
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int BO        = $clog2(BYTES);
    localparam int ROWS      = RAM_SIZE / (NUM_BANKS * BYTES);
    localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BANK_W    = (NUM_BANKS > 1) ? BANK_BITS : 1;
    localparam int WW        = ADDR_WIDTH - BO;

    typedef enum logic [1:0] {S_INIT, S_WAKE, S_READY} state_t;

    state_t             state, state_nxt;
    logic [ROW_W-1:0]   init_cnt, cnt_nxt;

    logic [WW-1:0]      word, row_full, bank_full;
    logic [ROW_W-1:0]   row;
    logic [BANK_W-1:0]  bank;
    logic               unused_bits;

    logic               initing, accept;
    logic [NUM_BANKS-1:0]  bank_en;
    logic                  bank_we;
    logic [BYTES-1:0]      bank_be;
    logic [ROW_W-1:0]      bank_addr;
    logic [DATA_WIDTH-1:0] bank_wdata;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    logic                  valid1, bypass1;
    logic [BANK_W-1:0]     bank1;
    logic [DATA_WIDTH-1:0] bdata1, resp_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    assign word        = addr_i[ADDR_WIDTH-1:BO];
    assign row_full    = word >> BANK_BITS;
    assign bank_full   = word & WW'(NUM_BANKS - 1);
    assign row         = row_full[ROW_W-1:0];
    assign bank        = bank_full[BANK_W-1:0];
    assign unused_bits = ^{addr_i, row_full, bank_full};

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state    <= (INIT_EN != 0) ? S_INIT : S_WAKE;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = init_cnt;
        case (state)
            S_INIT: begin
                if (init_cnt == ROW_W'(ROWS - 1)) begin
                    state_nxt = S_READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = init_cnt + ROW_W'(1);
                end
            end
            S_WAKE:  state_nxt = S_READY;
            S_READY: state_nxt = S_READY;
            default: state_nxt = S_READY;
        endcase
    end

    // Outputs are gated by rst_i so nothing leaks out while reset is held.
    assign initing     = (state == S_INIT) && !rst_i;
    assign gnt_o       = (state == S_READY) && req_i && !rst_i;
    assign init_done_o = (state == S_READY) && !rst_i;
    assign accept      = gnt_o;

    assign bank_we    = initing | we_i;
    assign bank_be    = initing ? '1 : be_i;
    assign bank_addr  = initing ? init_cnt : row;
    assign bank_wdata = initing ? '0 : wdata_i;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_en[b] = initing | (accept & ~bypass_en_i & (bank == BANK_W'(b)));

        sp_ram #(
            .DEPTH      (ROWS),
            .DATA_WIDTH (DATA_WIDTH),
            .AW         (ROW_W)
        ) u_ram (
            .clk   (clk),
            .en    (bank_en[b]),
            .we    (bank_we),
            .be    (bank_be),
            .addr  (bank_addr),
            .wdata (bank_wdata),
            .rdata (bank_rdata[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            valid1  <= 1'b0;
            bypass1 <= 1'b0;
            bank1   <= '0;
            bdata1  <= '0;
        end else begin
            valid1 <= accept;
            if (accept) begin
                bypass1 <= bypass_en_i;
                bank1   <= bank;
                bdata1  <= wdata_i;
            end
        end
    end

    assign resp_data = bypass1 ? bdata1 : bank_rdata[bank1];

    if (OUT_REG != 0) begin : g_oreg
        logic                  valid2;
        logic [DATA_WIDTH-1:0] data2;

        always_ff @(posedge clk) begin
            if (rst_i) begin
                valid2 <= 1'b0;
                data2  <= '0;
            end else begin
                valid2 <= valid1;
                if (valid1) data2 <= resp_data;
            end
        end

        assign out_valid = valid2;
        assign out_data  = data2;
    end else begin : g_ocomb
        logic [DATA_WIDTH-1:0] hold;

        always_ff @(posedge clk) begin
            if (rst_i) hold <= '0;
            else if (valid1) hold <= resp_data;
        end

        assign out_valid = valid1;
        assign out_data  = valid1 ? resp_data : hold;
    end

    assign rvalid_o = out_valid && !rst_i;
    assign rdata_o  = rst_i ? '0 : out_data;
endmodule
